rpn_sequencer: RTL and testbench
================================

# rpn_sequencer

Reverse-Polish token sequencer that sits directly upstream of the LIFO stack block and drives its push/pop/data_in port while consuming its data_out/full. It accepts a stream of operator/operand tokens over a valid/ready handshake, pops operands, computes a WIDTH-bit ALU result and pushes it back. It tracks stack occupancy itself, because the stack provides no empty flag, and it flags underflow/overflow.

## Interface
- WIDTH, 8: datapath width, equal to the stack WIDTH.
- ADDR_WIDTH, 4: equal to the stack ADDR_WIDTH; DEPTH = 2**ADDR_WIDTH.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- tok_valid  in  1  token offered.
- tok_ready  out  1  sequencer accepts token this cycle.
- tok_op  in  3  000 PUSH, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 DROP, 111 PEEK.
- tok_data  in  WIDTH  immediate for PUSH; ignored otherwise.
- stk_push  out  1  push strobe to stack.
- stk_pop  out  1  pop strobe to stack.
- stk_data_in  out  WIDTH  data to push.
- stk_data_out  in  WIDTH  popped value, valid the cycle after stk_pop.
- stk_full  in  1  stack full flag.
- res_valid  out  1  one-cycle pulse: result or peek value on res_data.
- res_data  out  WIDTH  result value.
- depth  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- err  out  2  sticky: bit0 underflow, bit1 overflow.

## Operation
- FSM states: IDLE, PUSHI, POPA, POPB, WAITB, WAITA, PUSHR.
- tok_ready = 1 only in IDLE and not in reset. A token is accepted on tok_valid && tok_ready; tok_op and tok_data are latched.
- PUSH: IDLE→PUSHI (stk_push=1, stk_data_in=latched imm, depth+1)→IDLE.
- Binary op (ADD/SUB/AND/OR/XOR): IDLE→POPA (stk_pop)→POPB (stk_pop; capture A=stk_data_out)→WAITB (capture B=stk_data_out)→PUSHR (stk_push, stk_data_in=res_data=B op A, res_valid=1)→IDLE. Net depth −1.
- SUB = B − A, where A is the former top of stack and B is the value beneath it.
- DROP: IDLE→POPA→IDLE; depth−1; no res_valid.
- PEEK: IDLE→POPA→WAITA (capture A)→PUSHR (push A back, res_data=A, res_valid=1)→IDLE; depth unchanged.
- Depth updates on the same edge as the corresponding strobe.
- Underflow check at accept time:
  - binary op with depth<2, or DROP/PEEK with depth==0;
  - token is consumed, err[0] set, no stack strobes, FSM stays IDLE.
- Overflow check at accept time:
  - PUSH with depth==DEPTH or stk_full=1;
  - token is consumed, err[1] set, no push.
- Arithmetic is modulo 2^WIDTH unless the saturation feature is enabled (see Configuration).
- err clears only on reset.
- Stack contents are not cleared by this block. The stack must be reset together with it.

## Timing
- Reset values: tok_ready=0, stk_push=0, stk_pop=0, stk_data_in=0, res_valid=0, res_data=0, depth=0, err=00, state IDLE.
- While reset is high, all strobes are forced low combinationally.
- Reset mid-operation aborts the operation and returns to IDLE. depth=0; any captured operands are discarded.
- Latencies are measured from the accept edge, cycle 0:
  - PUSH: push in cycle 1; tok_ready returns in cycle 2.
  - Binary: pops in cycles 1–2; push and res_valid in cycle 4; tok_ready in cycle 5.
  - PEEK: pop in cycle 1; push and res_valid in cycle 3; tok_ready in cycle 4.
  - DROP: pop in cycle 1; tok_ready in cycle 2.
- stk_push and stk_pop are never asserted in the same cycle.
- A binary op at depth==DEPTH is legal: the pops free space before the push.

## Configuration
- RPN_SEQ_SAT_EN defined: ADD and SUB saturate unsigned.
  - ADD clamps to all-ones on carry-out.
  - SUB clamps to 0 when B<A.
- RPN_SEQ_SAT_EN undefined: ADD and SUB wrap modulo 2^WIDTH.
- Logic ops are unaffected in both cases.

## Test plan
- PUSH 3, PUSH 5, SUB → res_valid with res_data=0xFE (wrap) or 0x00 (RPN_SEQ_SAT_EN); depth=1; result pushed.
- PUSH 0xF0, PUSH 0x20, ADD → 0x10 without the macro, 0xFF with it; res_valid exactly in cycle 4 after accept.
- Reset, then ADD → err=01, no stk_pop, depth=0, tok_ready back high next cycle.
- 16 PUSHes then a 17th PUSH → err=10, depth=16, no stk_push. A following XOR succeeds, leaving depth=15.
- PUSH 0x5A, PEEK → res_data=0x5A, depth=1; then DROP → depth=0, no res_valid.
- Assert reset during WAITB of an ADD → no push follows; all outputs return to reset values; depth=0.

Source files
------------

// File: rtl/rpn_sequencer.sv
// Reverse-Polish token sequencer driving an external LIFO stack, with its own occupancy and error tracking.
// Define RPN_SEQ_SAT_EN to make ADD/SUB saturate unsigned instead of wrapping.
module rpn_sequencer #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic [2:0]            tok_op,
  input  logic [WIDTH-1:0]      tok_data,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH-1:0]      stk_data_in,
  input  logic [WIDTH-1:0]      stk_data_out,
  input  logic                  stk_full,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic [ADDR_WIDTH:0]   depth,
  output logic [1:0]            err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_MAX  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_TWO  = (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH:0] DEPTH_ZERO = '0;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_DROP = 3'b110;
  localparam logic [2:0] OP_PEEK = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    PUSHI,
    POPA,
    POPB,
    WAITB,
    WAITA,
    PUSHR
  } state_t;

  state_t               state;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     a_q;
  logic                 push_q;
  logic                 pop_q;
  logic                 res_valid_q;
  logic [WIDTH-1:0]     data_in_q;
  logic [WIDTH-1:0]     res_data_q;
  logic [ADDR_WIDTH:0]  depth_q;
  logic [1:0]           err_q;

  // b is the value beneath the former top a, so SUB yields b - a.
  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] r;
`ifdef RPN_SEQ_SAT_EN
    logic [WIDTH:0] sum;
    sum = {1'b0, b} + {1'b0, a};
`endif
    r = a;
    case (op)
`ifdef RPN_SEQ_SAT_EN
      OP_ADD:  r = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      OP_SUB:  r = (b < a) ? '0 : (b - a);
`else
      OP_ADD:  r = b + a;
      OP_SUB:  r = b - a;
`endif
      OP_AND:  r = b & a;
      OP_OR:   r = b | a;
      OP_XOR:  r = b ^ a;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic is_binary(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

  // Strobes are registered on the same edge that moves depth, so occupancy always matches the stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= OP_PUSH;
      a_q         <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      res_valid_q <= 1'b0;
      data_in_q   <= '0;
      res_data_q  <= '0;
      depth_q     <= DEPTH_ZERO;
      err_q       <= 2'b00;
    end else begin
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      res_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tok_valid) begin
            op_q <= tok_op;
            if (tok_op == OP_PUSH) begin
              if ((depth_q == DEPTH_MAX) || stk_full) begin
                err_q[1] <= 1'b1;
              end else begin
                push_q    <= 1'b1;
                data_in_q <= tok_data;
                depth_q   <= depth_q + DEPTH_ONE;
                state     <= PUSHI;
              end
            end else if (is_binary(tok_op)) begin
              if (depth_q < DEPTH_TWO) begin
                err_q[0] <= 1'b1;
              end else begin
                pop_q   <= 1'b1;
                depth_q <= depth_q - DEPTH_ONE;
                state   <= POPA;
              end
            end else begin
              if (depth_q == DEPTH_ZERO) begin
                err_q[0] <= 1'b1;
              end else begin
                pop_q   <= 1'b1;
                depth_q <= depth_q - DEPTH_ONE;
                state   <= POPA;
              end
            end
          end
        end
        PUSHI: state <= IDLE;
        POPA: begin
          if (op_q == OP_DROP) begin
            state <= IDLE;
          end else if (op_q == OP_PEEK) begin
            state <= WAITA;
          end else begin
            pop_q   <= 1'b1;
            depth_q <= depth_q - DEPTH_ONE;
            state   <= POPB;
          end
        end
        POPB: begin
          a_q   <= stk_data_out;
          state <= WAITB;
        end
        // stk_data_out now holds B; the result is formed straight from it.
        WAITB: begin
          data_in_q   <= alu(op_q, stk_data_out, a_q);
          res_data_q  <= alu(op_q, stk_data_out, a_q);
          push_q      <= 1'b1;
          res_valid_q <= 1'b1;
          depth_q     <= depth_q + DEPTH_ONE;
          state       <= PUSHR;
        end
        WAITA: begin
          a_q         <= stk_data_out;
          data_in_q   <= stk_data_out;
          res_data_q  <= stk_data_out;
          push_q      <= 1'b1;
          res_valid_q <= 1'b1;
          depth_q     <= depth_q + DEPTH_ONE;
          state       <= PUSHR;
        end
        PUSHR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign tok_ready   = (state == IDLE) && !reset;
  assign stk_push    = push_q && !reset;
  assign stk_pop     = pop_q && !reset;
  assign res_valid   = res_valid_q && !reset;
  assign stk_data_in = data_in_q;
  assign res_data    = res_data_q;
  assign depth       = depth_q;
  assign err         = err_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Randomized scoreboard bench for rpn_sequencer with a behavioural LIFO attached and a queue-based RPN model.
// Honours RPN_SEQ_SAT_EN in its reference model.
module tb_rpn_sequencer;

  logic       clk;
  logic       reset;
  logic       tok_valid;
  logic       tok_ready;
  logic [2:0] tok_op;
  logic [7:0] tok_data;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_in;
  logic [7:0] stk_data_out;
  logic       stk_full;
  logic       res_valid;
  logic [7:0] res_data;
  logic [4:0] depth;
  logic [1:0] err;

  rpn_sequencer #(.WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_op(tok_op), .tok_data(tok_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out), .stk_full(stk_full),
    .res_valid(res_valid), .res_data(res_data), .depth(depth), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int data; int cyc; } exp_t;
  exp_t exp_q[$];
  int   model[$];
  int   ref_err;
  int   n_compared;
  int   n_mismatched;
  int   cyc;
  int   push_cnt;
  int   pop_cnt;

  // Stack that the sequencer drives; reset together with it.
  logic [7:0] tb_mem [0:15];
  int sp;
  always @(posedge clk) begin
    if (reset) sp <= 0;
    else if (stk_push && sp < 16) begin
      tb_mem[sp] <= stk_data_in;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_data_out <= tb_mem[sp-1];
      sp <= sp - 1;
    end
  end
  assign stk_full = (sp == 16);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int refAlu(input int op, input int b, input int a);
    int s;
    case (op)
      1: begin
        s = b + a;
`ifdef RPN_SEQ_SAT_EN
        if (s > 255) s = 255;
`endif
        return s & 255;
      end
      2: begin
`ifdef RPN_SEQ_SAT_EN
        if (b < a) return 0;
`endif
        return (b - a) & 255;
      end
      3: return b & a;
      4: return b | a;
      5: return b ^ a;
      default: return a;
    endcase
  endfunction

  // Monitor: counts strobes and scores every result pulse against the expected queue.
  always @(negedge clk) begin
    if (stk_push) push_cnt++;
    if (stk_pop) pop_cnt++;
    if (stk_push || stk_pop) checkOutput("push_pop_exclusive", int'(stk_push && stk_pop), 0);
    if (res_valid) begin
      if (exp_q.size() == 0) checkOutput("res_valid_unexpected", int'(res_valid), 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("res_data", int'(res_data), e.data);
        checkOutput("res_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    tok_valid = 1'b0;
    model.delete();
    exp_q.delete();
    ref_err = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int op, input int data);
    int k, base_push, base_pop, acc, lat, e_push, e_pop, a, b, r;
    exp_t e;
    k = 0;
    while (!tok_ready && k < 50) begin @(negedge clk); k++; end
    if (!tok_ready) checkOutput("idle_wait_tok_ready", int'(tok_ready), 1);
    base_push = push_cnt;
    base_pop  = pop_cnt;
    tok_valid = 1'b1;
    tok_op    = 3'(op);
    tok_data  = 8'(data);
    @(negedge clk);
    tok_valid = 1'b0;
    acc = cyc;
    lat = 1; e_push = 0; e_pop = 0;
    if (op == 0) begin
      if (model.size() == 16) ref_err |= 2;
      else begin model.push_back(data & 255); lat = 2; e_push = 1; end
    end else if (op >= 1 && op <= 5) begin
      if (model.size() < 2) ref_err |= 1;
      else begin
        a = model.pop_back();
        b = model.pop_back();
        r = refAlu(op, b, a);
        model.push_back(r);
        e.data = r; e.cyc = acc + 3;
        exp_q.push_back(e);
        lat = 5; e_pop = 2; e_push = 1;
      end
    end else if (op == 6) begin
      if (model.size() == 0) ref_err |= 1;
      else begin void'(model.pop_back()); lat = 2; e_pop = 1; end
    end else begin
      if (model.size() == 0) ref_err |= 1;
      else begin
        e.data = model[$]; e.cyc = acc + 2;
        exp_q.push_back(e);
        lat = 4; e_pop = 1; e_push = 1;
      end
    end
    k = 1;
    while (!tok_ready && k < 20) begin @(negedge clk); k++; end
    checkOutput("ready_latency", k, lat);
    checkOutput("push_count", push_cnt - base_push, e_push);
    checkOutput("pop_count", pop_cnt - base_pop, e_pop);
    checkOutput("depth", int'(depth), model.size());
    checkOutput("err", int'(err), ref_err);
    if (model.size() > 0 && sp > 0) checkOutput("stack_top", int'(tb_mem[sp-1]), model[$]);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base_push;
    n_compared = 0; n_mismatched = 0; cyc = 0; push_cnt = 0; pop_cnt = 0; ref_err = 0;
    reset = 1'b1; tok_valid = 1'b0; tok_op = 3'd0; tok_data = 8'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_tok_ready", int'(tok_ready), 0);
    checkOutput("reset_strobes", int'({stk_push, stk_pop, res_valid}), 0);
    checkOutput("reset_depth", int'(depth), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_res_data", int'(res_data), 0);
    checkOutput("reset_stk_data_in", int'(stk_data_in), 0);
    reset = 1'b0;

    // Wrap/saturate subtract and add.
    applyStimulus(0, 3); applyStimulus(0, 5); applyStimulus(2, 0);
    applyStimulus(6, 0);
    applyStimulus(0, 8'hF0); applyStimulus(0, 8'h20); applyStimulus(1, 0);
    applyStimulus(6, 0);

    // Underflow from empty.
    doReset();
    applyStimulus(1, 0);

    // Fill, overflow, then a binary op at full depth.
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(0, int'($urandom_range(0, 255)));
    applyStimulus(5, 0);

    // Peek then drop.
    doReset();
    applyStimulus(0, 8'h5A); applyStimulus(7, 0); applyStimulus(6, 0);

    // Reset landing in WAITB of an ADD.
    doReset();
    applyStimulus(0, 8'h11); applyStimulus(0, 8'h22);
    tok_valid = 1'b1; tok_op = 3'd1;
    @(negedge clk);
    tok_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model.delete(); exp_q.delete(); ref_err = 0;
    base_push = push_cnt;
    @(negedge clk);
    checkOutput("midreset_tok_ready", int'(tok_ready), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    checkOutput("midreset_no_push", push_cnt - base_push, 0);
    checkOutput("midreset_depth", int'(depth), 0);
    checkOutput("midreset_err", int'(err), 0);
    checkOutput("midreset_res_data", int'(res_data), 0);
    checkOutput("midreset_stk_data_in", int'(stk_data_in), 0);

    // Random token stream biased toward pushes.
    doReset();
    for (int i = 0; i < 250; i++) begin
      int r;
      r = int'($urandom_range(0, 10));
      applyStimulus((r < 4) ? 0 : r - 3, int'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 6; i++) @(negedge clk);
    checkOutput("scoreboard_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
